// File: rtl/host_load_seq_if.sv
// host_load_seq_if
//   Bundles the word-source read port and the byte-wide host-controller
//   load handshake that host_load_seq drives.
//
//   src_rd      sequencer -> source : one-cycle read strobe
//   src_idx     sequencer -> source : word index being read
//   src_data    source -> sequencer : word data, valid 1 cycle after src_rd
//   hc_data     sequencer -> host   : byte (registered)
//   hc_valid    sequencer -> host   : byte valid
//   hc_ack_data host -> sequencer   : byte accepted
//   hc_ack      host -> sequencer   : whole word (address + data) accepted
//
//   master : the sequencer side; slave : the source/host side.
interface host_load_seq_if;
  logic        src_rd;
  logic [31:0] src_idx;
  logic [31:0] src_data;
  logic [7:0]  hc_data;
  logic        hc_valid;
  logic        hc_ack_data;
  logic        hc_ack;

  modport master (
    output src_rd, src_idx, hc_data, hc_valid,
    input  src_data, hc_ack_data, hc_ack
  );

  modport slave (
    input  src_rd, src_idx, hc_data, hc_valid,
    output src_data, hc_ack_data, hc_ack
  );
endinterface

// File: rtl/host_load_seq.sv
// host_load_seq
//   Streams WORD_COUNT 32-bit words from a synchronous word source into the
//   host controller's byte-wide load port. Each word goes out as 4 address
//   bytes (BASE_ADDR+idx) followed by 4 data bytes, LSB first, one
//   valid/ack handshake per byte, then waits for the word acknowledge.
//   Any single wait longer than TIMEOUT cycles parks the block in ERR.
//
//   wb_clk_i   in   clock
//   wb_rst_i   in   synchronous active-high reset
//   start_i    in   begin a run (honoured only when not busy)
//   bus_io     master modport of host_load_seq_if (source + host handshake)
//   hc_done_o  out  run complete, held until next start or reset
//   busy_o     out  run in progress
//   err_o      out  ack timeout, held until next start or reset
module host_load_seq #(
  parameter int unsigned WORD_COUNT = 1456,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0040,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            start_i,
  host_load_seq_if.master bus_io,
  output logic            hc_done_o,
  output logic            busy_o,
  output logic            err_o
);

  localparam int unsigned WCW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_SEND,
    S_GAP,
    S_WWACK,
    S_DONE,
    S_ERR
  } state_e;

  state_e         state_q;
  logic [31:0]    idx_q;
  logic [31:0]    addr_q;
  logic [31:0]    word_q;
  logic [2:0]     bcnt_q;
  logic [WCW-1:0] wcnt_q;
  logic           src_rd_q;
  logic [7:0]     hc_data_q;
  logic           hc_valid_q;
  logic           done_q;
  logic           err_q;

  logic [31:0]    addr_d;
  logic [2:0]     bcnt_d;
  logic [WCW-1:0] wcnt_d;
  logic           wait_expired;
  logic           last_word;

  // Byte k of the frame: 0..3 address bytes, 4..7 data bytes, LSB first.
  function automatic logic [7:0] frame_byte(input logic [31:0] a,
                                            input logic [31:0] d,
                                            input logic [2:0]  k);
    logic [63:0] f;
    f = {d, a};
    return f[{k, 3'b000} +: 8];
  endfunction

  always_comb begin
    addr_d       = BASE_ADDR + idx_q;
    bcnt_d       = bcnt_q + 3'd1;
    wcnt_d       = (wcnt_q == '1) ? wcnt_q : wcnt_q + WCW'(1);
    wait_expired = (wcnt_q == WCW'(TIMEOUT - 1));
    last_word    = (idx_q == 32'(WORD_COUNT - 1));
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      addr_q     <= '0;
      word_q     <= '0;
      bcnt_q     <= '0;
      wcnt_q     <= '0;
      src_rd_q   <= 1'b0;
      hc_data_q  <= '0;
      hc_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      src_rd_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_i) begin
            idx_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (WORD_COUNT == 0) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              src_rd_q <= 1'b1;
              state_q  <= S_FETCH;
            end
          end
        end

        S_FETCH: state_q <= S_LATCH;

        S_LATCH: begin
          // Source data is valid in this cycle; byte 0 comes straight from
          // the freshly computed address so it is visible on SEND entry.
          word_q     <= bus_io.src_data;
          addr_q     <= addr_d;
          bcnt_q     <= '0;
          wcnt_q     <= '0;
          hc_data_q  <= addr_d[7:0];
          hc_valid_q <= 1'b1;
          state_q    <= S_SEND;
        end

        S_SEND: begin
          if (bus_io.hc_ack_data) begin
            hc_valid_q <= 1'b0;
            if (bcnt_q == 3'd7) begin
              wcnt_q  <= '0;
              state_q <= S_WWACK;
            end else begin
              state_q <= S_GAP;
            end
          end else if (wait_expired) begin
            hc_valid_q <= 1'b0;
            err_q      <= 1'b1;
            state_q    <= S_ERR;
          end else begin
            wcnt_q <= wcnt_d;
          end
        end

        S_GAP: begin
          bcnt_q     <= bcnt_d;
          hc_data_q  <= frame_byte(addr_q, word_q, bcnt_d);
          hc_valid_q <= 1'b1;
          wcnt_q     <= '0;
          state_q    <= S_SEND;
        end

        S_WWACK: begin
          if (bus_io.hc_ack) begin
            idx_q <= idx_q + 32'd1;
            if (last_word) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              src_rd_q <= 1'b1;
              state_q  <= S_FETCH;
            end
          end else if (wait_expired) begin
            err_q   <= 1'b1;
            state_q <= S_ERR;
          end else begin
            wcnt_q <= wcnt_d;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus_io.src_rd   = src_rd_q;
  assign bus_io.src_idx  = idx_q;
  assign bus_io.hc_data  = hc_data_q;
  assign bus_io.hc_valid = hc_valid_q;
  assign hc_done_o       = done_q;
  assign err_o           = err_q;
  assign busy_o          = !(state_q inside {S_IDLE, S_DONE, S_ERR});

endmodule
